// File: rtl/ext_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ext_pkg
//  Description : Shared extension-mode encodings for the immediate extender.
//  Revision    : 1.0 - initial release
// ============================================================================
package ext_pkg;

    typedef logic [2:0] eop_t;

    localparam eop_t EXT_SIGN = 3'b000;  // sign-extend full immediate
    localparam eop_t EXT_ZERO = 3'b001;  // zero-extend full immediate
    localparam eop_t EXT_LUI  = 3'b010;  // immediate placed in the upper bits
    localparam eop_t EXT_BR   = 3'b011;  // sign-extended branch offset, shifted
    localparam eop_t EXT_SB   = 3'b100;  // sign-extend low byte
    localparam eop_t EXT_UB   = 3'b101;  // zero-extend low byte
    localparam eop_t EXT_WA   = 3'b110;  // sign-extend, word-aligned
    localparam eop_t EXT_ILL  = 3'b111;  // reserved / illegal

endpackage
`default_nettype wire

// File: rtl/ext_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ext_core
//  Description : Purely combinational immediate extender. Maps a raw
//                immediate and an extension mode to a DATA_W-bit result and
//                flags the reserved mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module ext_core
    import ext_pkg::*;
#(
    parameter int IMM_W    = 16,
    parameter int DATA_W   = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic [IMM_W-1:0]  imm,
    input  eop_t              EOp,
    output logic [DATA_W-1:0] ext_imm,
    output logic              err
);

    localparam int                c_LUI_SH  = DATA_W - IMM_W;
    localparam logic [DATA_W-1:0] c_WA_MASK = {{(DATA_W-2){1'b1}}, 2'b00};

    logic [DATA_W-1:0] w_sext;
    logic [DATA_W-1:0] w_zext;
    logic [DATA_W-1:0] w_sbyte;
    logic [DATA_W-1:0] w_ubyte;

    // Signed casts replicate the source MSB into the upper result bits.
    assign w_sext  = DATA_W'($signed(imm));
    assign w_zext  = DATA_W'(imm);
    assign w_sbyte = DATA_W'($signed(imm[7:0]));
    assign w_ubyte = DATA_W'(imm[7:0]);

    // Select the extended form; shifts are done at DATA_W so overflow bits drop.
    always_comb begin
        ext_imm = '0;
        err     = 1'b0;
        case (EOp)
            EXT_SIGN: ext_imm = w_sext;
            EXT_ZERO: ext_imm = w_zext;
            EXT_LUI:  ext_imm = w_zext << c_LUI_SH;
            EXT_BR:   ext_imm = w_sext << BR_SHIFT;
            EXT_SB:   ext_imm = w_sbyte;
            EXT_UB:   ext_imm = w_ubyte;
            EXT_WA:   ext_imm = w_sext & c_WA_MASK;
            EXT_ILL:  err     = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ext_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ext_pipe
//  Description : Registered immediate extender between ID and EX. One-cycle
//                latency, valid/ready handshake with a main entry (M) driving
//                the outputs and a skid entry (S) absorbing one beat of
//                back-pressure. Flush kills buffered beats; a saturating
//                counter tallies accepted illegal-mode beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module ext_pipe
    import ext_pkg::*;
#(
    parameter int IMM_W    = 16,
    parameter int DATA_W   = 32,
    parameter int BR_SHIFT = 2,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  imm,
    input  logic [2:0]        EOp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ext_imm,
    output logic              out_err,
    output logic [CNT_W-1:0]  err_cnt
);

    logic [DATA_W-1:0] w_ext;
    logic              w_err;
    logic              w_accept;
    logic              w_m_free;

    logic              r_m_valid;
    logic [DATA_W-1:0] r_m_data;
    logic              r_m_err;
    logic              r_s_valid;
    logic [DATA_W-1:0] r_s_data;
    logic              r_s_err;
    logic [CNT_W-1:0]  r_err_cnt;

    ext_core #(
        .IMM_W    (IMM_W),
        .DATA_W   (DATA_W),
        .BR_SHIFT (BR_SHIFT)
    ) u_core (
        .imm     (imm),
        .EOp     (EOp),
        .ext_imm (w_ext),
        .err     (w_err)
    );

    // in_ready depends only on the skid flag, so out_ready never reaches it.
    assign w_accept = in_valid && !r_s_valid;
    // M can take a new beat if it is empty or its current beat leaves this edge.
    assign w_m_free = !r_m_valid || out_ready;

    // M/S storage: S refills M first, otherwise a new beat lands in M or S.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_err   <= 1'b0;
            r_s_valid <= 1'b0;
            r_s_data  <= '0;
            r_s_err   <= 1'b0;
        end else if (flush) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
        end else if (w_m_free) begin
            if (r_s_valid) begin
                // S is only occupied while M is, so this is the M-drain case.
                r_m_valid <= 1'b1;
                r_m_data  <= r_s_data;
                r_m_err   <= r_s_err;
                r_s_valid <= 1'b0;
            end else begin
                r_m_valid <= w_accept;
                if (w_accept) begin
                    r_m_data <= w_ext;
                    r_m_err  <= w_err;
                end
            end
        end else if (w_accept) begin
            r_s_valid <= 1'b1;
            r_s_data  <= w_ext;
            r_s_err   <= w_err;
        end
    end

    // Count every accepted illegal beat, including ones a flush later discards.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_cnt <= '0;
        end else if (w_accept && w_err && (r_err_cnt != {CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign in_ready  = !r_s_valid;
    assign out_valid = r_m_valid;
    assign ext_imm   = r_m_data;
    assign out_err   = r_m_err;
    assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ext_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ext_pipe
//  Description : Self-checking bench for ext_pipe with a scoreboard queue.
//                A second instance with a 2-bit counter shares all inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ext_pipe;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] imm;
    logic [2:0]  EOp;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ext_imm;
    logic        out_err;
    logic [7:0]  err_cnt;

    logic        in_ready2;
    logic        out_valid2;
    logic [31:0] ext_imm2;
    logic        out_err2;
    logic [1:0]  err_cnt2;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    int          exp_cnt  = 0;
    int          exp_cnt2 = 0;
    beat_t       q[$];
    int          pop_cyc[$];

    ext_pipe #(.IMM_W(16), .DATA_W(32), .BR_SHIFT(2), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .imm(imm), .EOp(EOp), .out_valid(out_valid),
        .out_ready(out_ready), .ext_imm(ext_imm), .out_err(out_err),
        .err_cnt(err_cnt)
    );

    ext_pipe #(.IMM_W(16), .DATA_W(32), .BR_SHIFT(2), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready2), .imm(imm), .EOp(EOp), .out_valid(out_valid2),
        .out_ready(out_ready), .ext_imm(ext_imm2), .out_err(out_err2),
        .err_cnt(err_cnt2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference extension for IMM_W=16, DATA_W=32, BR_SHIFT=2.
    function automatic beat_t model(input logic [15:0] i, input logic [2:0] e);
        beat_t b;
        b.err = 1'b0;
        case (e)
            3'd0:    b.data = {{16{i[15]}}, i};
            3'd1:    b.data = {16'h0000, i};
            3'd2:    b.data = {i, 16'h0000};
            3'd3:    b.data = {{14{i[15]}}, i, 2'b00};
            3'd4:    b.data = {{24{i[7]}}, i[7:0]};
            3'd5:    b.data = {24'h000000, i[7:0]};
            3'd6:    b.data = {{16{i[15]}}, i[15:2], 2'b00};
            default: begin b.data = 32'h0; b.err = 1'b1; end
        endcase
        return b;
    endfunction

    // Scoreboard monitor: sampled mid-cycle, reflects what the next edge does.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            exp_cnt  = 0;
            exp_cnt2 = 0;
        end else begin
            check_val("out_valid", out_valid, q.size() != 0);
            check_val("in_ready", in_ready, q.size() < 2);
            check_val("err_cnt", err_cnt, exp_cnt);
            check_val("err_cnt2", err_cnt2, exp_cnt2);
            if (out_valid && q.size() != 0) begin
                check_val("ext_imm", ext_imm, q[0].data);
                check_val("out_err", out_err, q[0].err);
                if (out_ready && !flush) begin
                    void'(q.pop_front());
                    pop_cyc.push_back(cyc);
                end
            end
            if (in_valid && in_ready) begin
                if (EOp == 3'b111) begin
                    if (exp_cnt != 255) exp_cnt++;
                    if (exp_cnt2 != 3) exp_cnt2++;
                end
                if (!flush) q.push_back(model(imm, EOp));
            end
            if (flush) q.delete();
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until the handshake completes.
    task automatic send(input logic [15:0] i, input logic [2:0] e);
        bit done = 1'b0;
        imm      = i;
        EOp      = e;
        in_valid = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) check_val("send_timeout", 0, 1);
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        imm       = 16'h0;
        EOp       = 3'b000;
        out_ready = 1'b0;
        idle(3);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_ext_imm", ext_imm, 0);
        check_val("rst_out_err", out_err, 0);
        check_val("rst_err_cnt", err_cnt, 0);
        reset = 1'b0;
        idle(1);

        // Full-width modes, one beat at a time.
        out_ready = 1'b1;
        for (int e = 0; e < 4; e++) begin
            send(16'h8001, 3'(e));
            check_val("lat_valid", out_valid, 1);
            idle(1);
        end
        check_val("t1_br", ext_imm, 32'hFFFE0004);

        // Byte, aligned and illegal modes.
        for (int e = 4; e < 8; e++) begin
            send(16'h00F0, 3'(e));
            check_val("lat_valid", out_valid, 1);
            idle(1);
        end
        check_val("t2_err_cnt", err_cnt, 1);
        check_val("t2_err_cnt2", err_cnt2, 1);

        // Back-pressure: M and S fill, later beats stall, then drain in order.
        out_ready = 1'b0;
        send(16'h1111, 3'd0);
        send(16'h8222, 3'd0);
        check_val("t3_in_ready", in_ready, 0);
        fork
            begin
                send(16'h0333, 3'd2);
                send(16'hF444, 3'd3);
            end
            begin
                repeat (3) begin
                    @(negedge clk);
                    check_val("t3_stall_ready", in_ready, 0);
                    check_val("t3_hold_data", ext_imm, 32'h00001111);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(4);

        // Streaming throughput.
        pop_cyc.delete();
        for (int k = 0; k < 10; k++) send(16'(k * 16'h0123 + 16'h8000), 3'(k % 7));
        idle(3);
        check_val("t4_count", pop_cyc.size(), 10);
        if (pop_cyc.size() == 10) check_val("t4_span", pop_cyc[9] - pop_cyc[0], 9);

        // Flush with both entries full and a beat presented.
        out_ready = 1'b0;
        send(16'h0AAA, 3'd1);
        send(16'h0BBB, 3'd7);
        flush    = 1'b1;
        in_valid = 1'b1;
        imm      = 16'h0CCC;
        EOp      = 3'd0;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check_val("t5_out_valid", out_valid, 0);
        check_val("t5_in_ready", in_ready, 1);
        check_val("t5_err_cnt", err_cnt, 2);
        out_ready = 1'b1;
        idle(3);

        // Counter saturation on the narrow instance.
        for (int k = 0; k < 5; k++) send(16'(k), 3'd7);
        idle(2);
        check_val("t6_cnt", err_cnt, 7);
        check_val("t6_cnt2_sat", err_cnt2, 3);

        // Reset mid-stream wins over a presented beat.
        out_ready = 1'b0;
        send(16'h1234, 3'd0);
        send(16'h5678, 3'd7);
        reset    = 1'b1;
        in_valid = 1'b1;
        imm      = 16'h9999;
        EOp      = 3'd7;
        @(posedge clk);
        #1;
        check_val("t6_rst_out_valid", out_valid, 0);
        check_val("t6_rst_in_ready", in_ready, 1);
        check_val("t6_rst_ext_imm", ext_imm, 0);
        check_val("t6_rst_out_err", out_err, 0);
        check_val("t6_rst_err_cnt", err_cnt, 0);
        check_val("t6_rst_err_cnt2", err_cnt2, 0);
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(1);
        send(16'hFF80, 3'd4);
        idle(1);

        for (int k = 0; k < 100 && q.size() != 0; k++) idle(1);
        check_val("final_drain", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
